writeback_stage: RTL and testbench

Registered, parametrised writeback stage for the MIPS pipeline. It takes one retiring instruction per cycle from the memory stage over a valid/ready handshake and waits for an in-flight load response. It extracts and sign/zero-extends sub-word load data and selects among ALU, load and link (PC+8) results. It drives the register-file write port, a forwarding port and a retired-instruction counter.

---
 rtl/writeback_stage_pkg.sv | 21 ++
 rtl/writeback_stage_load_extract.sv | 35 +++
 rtl/writeback_stage.sv | 145 ++++++++++++++
 tb/tb_writeback_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: pipeline encodings
// in `pipes`, architectural constants in `common`.
package common;
    localparam int LINK_OFFSET = 8;
endpackage

package pipes;
    typedef enum logic [1:0] {
        ALU  = 2'd0,
        MEM  = 2'd1,
        LINK = 2'd2,
        NONE = 2'd3
    } wb_src_t;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_t;
endpackage

// File: rtl/writeback_stage_load_extract.sv
// Combinational sub-word load extraction: selects the addressed field of an
// aligned memory word and sign/zero-extends it to XLEN.
module load_extract
    import pipes::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  mem_size_t        size,
    input  logic             is_unsigned,
    output logic [XLEN-1:0]  result
);
    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    always_comb begin
        // Misaligned offsets are truncated down to the field's natural alignment.
        off_h  = offset & ~OFF_W'(1);
        off_w  = offset & ~OFF_W'(3);
        byte_v = rdata[{offset, 3'b000} +: 8];
        half_v = rdata[{off_h, 3'b000} +: 16];
        word_v = rdata[{off_w, 3'b000} +: 32];
        unique case (size)
            BYTE:    result = is_unsigned ? XLEN'(byte_v) : XLEN'($signed(byte_v));
            HALF:    result = is_unsigned ? XLEN'(half_v) : XLEN'($signed(half_v));
            WORD:    result = is_unsigned ? XLEN'(word_v) : XLEN'($signed(word_v));
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// MIPS writeback stage: accepts one retiring instruction per cycle, waits for
// load data when needed, and drives the register-file/forwarding write port.
module writeback_stage
    import pipes::*;
    import common::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5,
    parameter int CNT_W     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  wb_src_t              in_wb_src,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_pc,
    input  mem_size_t            in_mem_size,
    input  logic                 in_mem_unsigned,
    input  logic                 in_reg_write,
    input  logic [NREG_BITS-1:0] in_rd,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_rvalid,
    input  logic                 flush,
    output logic                 rf_we,
    output logic [NREG_BITS-1:0] rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 fwd_valid,
    output logic [NREG_BITS-1:0] fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic [CNT_W-1:0]     instret
);
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t               state_q, state_d;
    logic                 rf_we_q, rf_we_d;
    logic [NREG_BITS-1:0] rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]      rf_wd_q, rf_wd_d;
    logic                 ld_we_q, ld_we_d;
    logic [NREG_BITS-1:0] ld_rd_q, ld_rd_d;
    logic [OFF_W-1:0]     ld_off_q, ld_off_d;
    mem_size_t            ld_size_q, ld_size_d;
    logic                 ld_uns_q, ld_uns_d;
    logic [CNT_W-1:0]     instret_q, instret_d;

    logic                 accept;
    logic                 new_we;
    logic [XLEN-1:0]      new_wd;
    logic [XLEN-1:0]      ld_data;

    load_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extract (
        .rdata       (mem_rdata),
        .offset      (ld_off_q),
        .size        (ld_size_q),
        .is_unsigned (ld_uns_q),
        .result      (ld_data)
    );

    assign in_ready = (state_q != WAIT_MEM);

    always_comb begin
        accept    = in_valid & in_ready;
        new_we    = in_reg_write & (in_rd != '0);
        new_wd    = (in_wb_src == LINK) ? in_pc + XLEN'(LINK_OFFSET) : in_alu_result;

        state_d   = state_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        ld_we_d   = ld_we_q;
        ld_rd_d   = ld_rd_q;
        ld_off_d  = ld_off_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        instret_d = instret_q;

        if (state_q == WRITE) begin
            instret_d = instret_q + CNT_W'(1);
        end

        if (state_q == WAIT_MEM) begin
            // A flush kills the load even when its data arrives the same cycle.
            if (flush) begin
                state_d = IDLE;
            end else if (mem_rvalid) begin
                state_d = WRITE;
                rf_we_d = ld_we_q;
                rf_wa_d = ld_rd_q;
                rf_wd_d = ld_data;
            end
        end else if (accept) begin
            if (in_wb_src == MEM) begin
                state_d   = WAIT_MEM;
                ld_we_d   = new_we;
                ld_rd_d   = in_rd;
                ld_off_d  = in_alu_result[OFF_W-1:0];
                ld_size_d = in_mem_size;
                ld_uns_d  = in_mem_unsigned;
            end else begin
                state_d = WRITE;
                rf_we_d = new_we;
                rf_wa_d = in_rd;
                rf_wd_d = new_wd;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            ld_we_q   <= 1'b0;
            ld_rd_q   <= '0;
            ld_off_q  <= '0;
            ld_size_q <= BYTE;
            ld_uns_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            ld_we_q   <= ld_we_d;
            ld_rd_q   <= ld_rd_d;
            ld_off_q  <= ld_off_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            instret_q <= instret_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign fwd_valid = rf_we_q;
    assign fwd_rd    = rf_wa_q;
    assign fwd_data  = rf_wd_q;
    assign instret   = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver pushes expected writes,
// a negedge monitor pops and compares whenever rf_we is seen.
module tb_writeback_stage;
    import pipes::*;

    localparam int XLEN = 32;
    localparam int NRB  = 5;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, in_mem_unsigned, in_reg_write;
    wb_src_t         in_wb_src;
    mem_size_t       in_mem_size;
    logic [XLEN-1:0] in_alu_result, in_pc, mem_rdata, rf_wd, fwd_data;
    logic [NRB-1:0]  in_rd, rf_wa, fwd_rd;
    logic            mem_rvalid, flush, rf_we, fwd_valid;
    logic [CW-1:0]   instret;

    writeback_stage #(.XLEN(XLEN), .NREG_BITS(NRB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_src(in_wb_src), .in_alu_result(in_alu_result), .in_pc(in_pc),
        .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .flush(flush), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NRB-1:0]  rd;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   retired = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference load semantics: align the offset down to the field size,
    // take the field arithmetically, then sign-adjust if requested.
    function automatic logic [31:0] ref_load(input logic [31:0] raw, input int off,
                                             input mem_size_t sz, input bit uns);
        int     nb;
        longint v;
        nb  = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
        off = off - (off % nb);
        v   = longint'(raw >> (8 * off)) % (longint'(1) << (8 * nb));
        if (!uns && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(rf_wa), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rf_wa), 64'(e.rd));
                chk("wr_data", 64'(rf_wd), 64'(e.data));
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                chk("fwd_port", {26'd0, fwd_valid, fwd_rd, fwd_data}, {26'd0, 1'b1, e.rd, e.data});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            flush      = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic check_idle();
        idle(2);
        @(negedge clk);
        chk("instret", 64'(instret), 64'(retired % 16));
        chk("idle_rf_we", 64'(rf_we), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic issue(input wb_src_t src, input logic [31:0] alu, input logic [31:0] pc,
                         input mem_size_t sz, input bit uns, input bit rw,
                         input logic [NRB-1:0] rd, input logic [31:0] rdata,
                         input int delay, input bit do_flush, input bit flush_rv);
        exp_t e;
        in_valid        = 1'b1;
        in_wb_src       = src;
        in_alu_result   = alu;
        in_pc           = pc;
        in_mem_size     = sz;
        in_mem_unsigned = uns;
        in_reg_write    = rw;
        in_rd           = rd;
        // Load-side noise must be ignored outside WAIT_MEM.
        mem_rvalid      = 1'($urandom_range(0, 1));
        mem_rdata       = $urandom;
        flush           = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        chk("in_ready_accept", 64'(in_ready), 64'(1));
        if (src != MEM) begin
            retired++;
            if (rw && rd != 0) begin
                e.rd   = rd;
                e.data = (src == LINK) ? pc + 32'd8 : alu;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        if (src == MEM) begin
            for (int i = 0; i < delay; i++) begin
                in_valid      = 1'($urandom_range(0, 1));
                in_wb_src     = wb_src_t'($urandom_range(0, 3));
                in_rd         = NRB'($urandom);
                in_alu_result = $urandom;
                @(negedge clk);
                chk("in_ready_wait", 64'(in_ready), 64'(0));
                @(posedge clk); #1;
            end
            mem_rvalid = do_flush ? flush_rv : 1'b1;
            flush      = do_flush;
            mem_rdata  = rdata;
            @(negedge clk);
            chk("in_ready_wait", 64'(in_ready), 64'(0));
            if (!do_flush) begin
                retired++;
                if (rw && rd != 0) begin
                    e.rd   = rd;
                    e.data = ref_load(rdata, int'(alu[1:0]), sz, uns);
                    e.cyc  = cyc + 1;
                    exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
            in_valid   = 1'b0;
            mem_rvalid = 1'b0;
            flush      = 1'b0;
            if (do_flush) begin
                @(negedge clk);
                chk("ready_after_flush", 64'(in_ready), 64'(1));
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int r;
        wb_src_t src;
        reset = 1'b1;
        in_valid = 1'b0; in_wb_src = ALU; in_alu_result = '0; in_pc = '0;
        in_mem_size = BYTE; in_mem_unsigned = 1'b0; in_reg_write = 1'b0; in_rd = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; flush = 1'b0;
        #1;
        chk("rst_we_wa", {58'd0, rf_we, rf_wa}, 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        chk("rst_fwd", {26'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
        chk("rst_instret", 64'(instret), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Back-to-back ALU ops
        issue(ALU, 32'h11, 32'h100, WORD, 0, 1, 5'd3, 0, 0, 0, 0);
        issue(ALU, 32'h22, 32'h104, WORD, 0, 1, 5'd4, 0, 0, 0, 0);
        issue(ALU, 32'h33, 32'h108, WORD, 0, 1, 5'd5, 0, 0, 0, 0);
        check_idle();

        // Sub-word loads
        issue(MEM, 32'h1003, 0, BYTE, 0, 1, 5'd7, 32'h80FF_1234, 2, 0, 0);
        issue(MEM, 32'h2002, 0, HALF, 1, 1, 5'd8, 32'h8001_0000, 0, 0, 0);
        issue(MEM, 32'h2002, 0, HALF, 0, 1, 5'd9, 32'h8001_0000, 1, 0, 0);
        issue(MEM, 32'h2001, 0, DOUBLE, 0, 1, 5'd10, 32'hCAFE_F00D, 0, 0, 0);

        // LINK, r0, wrap of pc+8, NONE
        issue(LINK, 0, 32'h0040_0010, WORD, 0, 1, 5'd31, 0, 0, 0, 0);
        issue(ALU, 32'hDEAD, 0, WORD, 0, 1, 5'd0, 0, 0, 0, 0);
        issue(LINK, 0, 32'hFFFF_FFFC, WORD, 0, 1, 5'd2, 0, 0, 0, 0);
        issue(NONE, 32'h5, 0, WORD, 0, 1, 5'd6, 0, 0, 0, 0);
        check_idle();

        // Flush with and without same-cycle data
        issue(MEM, 32'h0, 0, WORD, 0, 1, 5'd11, 32'h1234_5678, 1, 1, 1);
        issue(MEM, 32'h0, 0, WORD, 0, 1, 5'd12, 32'h1234_5678, 0, 1, 0);
        check_idle();

        // Reset while a load waits for data
        in_valid = 1'b1; in_wb_src = MEM; in_alu_result = '0; in_rd = 5'd9;
        in_reg_write = 1'b1; in_mem_size = WORD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("wait_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("midrst_we_wa", {58'd0, rf_we, rf_wa}, 64'd0);
        chk("midrst_wd", 64'(rf_wd), 64'd0);
        chk("midrst_instret", 64'(instret), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        retired = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check_idle();

        // Counter wrap: 17 retires on a 4-bit counter
        for (int i = 0; i < 17; i++)
            issue(NONE, 0, 0, WORD, 0, 0, 5'd0, 0, 0, 0, 0);
        check_idle();

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            src = (r < 4) ? ALU : (r < 7) ? MEM : (r == 7) ? LINK : NONE;
            issue(src, $urandom, $urandom, mem_size_t'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), NRB'($urandom),
                  $urandom, int'($urandom_range(0, 3)),
                  (src == MEM) && ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            if (n % 50 == 49) check_idle();
        end

        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_instret", 64'(instret), 64'(retired % 16));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
